keymgr_op_ctrl: RTL and testbench
=================================

# keymgr_op_ctrl

Key manager operation controller: the responder end of the `op_start` / `op` / `op_done` operation interface. It accepts one key manager operation at a time and runs it for a fixed latency. It advances the key manager state machine, flags illegal requests, and drives the `data_hw_en` / `data_sw_en` / `data_valid` output gating strictly from current state and the completed operation. No grant ever depends on operation history.

## Interface
- `OP_LATENCY`, default 4: cycles from accept to `op_done`; legal range 1..15.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `op_start`  in  1  level request from initiator; held until `op_done` is seen.
- `op`  in  3  opcode: OpAdvance=0, OpGenId=1, OpGenSwOut=2, OpGenHwOut=3, OpDisable=4; 5..7 illegal.
- `op_done`  out  1  one-cycle completion pulse.
- `op_err`  out  1  valid only with `op_done`; 1 = operation rejected.
- `op_busy`  out  1  operation in flight.
- `state_o`  out  10  current state encoding.
- `data_hw_en`  out  1  hardware key output enable.
- `data_sw_en`  out  1  software key output enable.
- `data_valid`  out  1  one-cycle pulse: generated output valid.

## Operation
- State encodings:
  - StCtrlReset 10'b1101100001
  - StCtrlInit 10'b0100000100
  - StCtrlCreatorRootKey 10'b1000011101
  - StCtrlOwnerIntKey 10'b0011110010
  - StCtrlOwnerKey 10'b1101111110
  - StCtrlDisabled 10'b0110001011
- Any other value of the state register forces Disabled on the next edge. No output enable is granted from an invalid encoding.
- Internal FSM: Idle, Busy, Done.
  - Idle→Busy on accept.
  - Busy→Done when the latency counter expires.
  - Done→Idle unconditionally.
- Accept condition: Idle, `op_start`=1, and armed. At accept, `op` is latched; later changes to `op` are ignored.
- Arming: cleared at accept. Set at any edge in Idle where `op_start`=0. Set out of reset.
- Dropping `op_start` mid-operation does not abort; the operation completes.
- OpAdvance steps Reset→Init→CreatorRootKey→OwnerIntKey→OwnerKey→Disabled. In Disabled it errors and the state holds.
- OpGenId, OpGenSwOut, OpGenHwOut are legal only in CreatorRootKey, OwnerIntKey, OwnerKey.
  - Legal gen op: `op_err`=0, `data_valid` pulses with `op_done`.
  - GenSwOut additionally sets `data_sw_en`; GenHwOut additionally sets `data_hw_en`.
  - In Reset, Init or Disabled: `op_err`=1, no enable or valid.
- OpDisable: any state→Disabled, `op_err`=0.
- Opcodes 5..7: `op_err`=1, state unchanged.
- `data_sw_en` / `data_hw_en` are sticky.
  - Cleared at the next accept of any op.
  - Cleared on any state change.
  - Forced 0 whenever the state is not a key state.
- Enables and errors are functions of current state and the latched op only. No counters, sequence matching or magic values may influence them.

## Timing
- Reset values:
  - `op_done`=0, `op_err`=0, `op_busy`=0, `data_valid`=0
  - `data_hw_en`=0, `data_sw_en`=0
  - `state_o`=StCtrlReset; internal FSM Idle, armed=1
- Reset asserted mid-operation discards the operation: no `op_done`, and all of the above values apply after the reset edge.
- Accept at edge T0. `op_busy`=1 for cycles T0+1 .. T0+OP_LATENCY−1.
- Cycle T0+OP_LATENCY:
  - `op_done`=1, `op_busy`=0
  - `op_err`, `data_valid`, `state_o` and the enables already reflect the result
- With OP_LATENCY=1, `op_done` is in cycle T0+1 and `op_busy` never asserts.
- Earliest next accept is the edge ending cycle T0+OP_LATENCY+1, and only if `op_start` was sampled 0 at or after the Done cycle.
- `op_start` held high across `op_done` does not re-trigger.
- Latency counter: 4 bits, loaded with OP_LATENCY−1 at accept, decremented in Busy.

## Test plan
- Reset, then OpAdvance ×4 (OP_LATENCY=4, `op_start` dropped after each `op_done`):
  - `state_o` ends at 10'b1101111110
  - each `op_done` 4 cycles after its accept, `op_err`=0
- From Reset, issue OpAdvance, OpGenId, OpGenSwOut, OpGenHwOut:
  - state is Init after the first op, so the three gen ops each return `op_err`=1
  - `data_hw_en` = `data_sw_en` = `data_valid` = 0 throughout; no history-based bypass
- In OwnerKey, OpGenHwOut:
  - `op_done`=`data_valid`=`data_hw_en`=1, `data_sw_en`=0
  - next OpGenId accept clears `data_hw_en` in the following cycle
- `op_start` held high for 20 cycles: exactly one `op_done`. Opcode 6: `op_err`=1, state unchanged.
- `rst_n`=0 for one cycle at T0+2 of an OpAdvance: no `op_done`, `state_o`=StCtrlReset, `op_busy`=0.
- OpDisable from OwnerIntKey:
  - `state_o`=10'b0110001011, `op_err`=0
  - subsequent OpAdvance returns `op_err`=1 and all enables stay 0

Source files
------------

// File: rtl/keymgr_op_ctrl.sv
// -----------------------------------------------------------------------------
// keymgr_op_ctrl
//
// Responder end of the key manager op_start / op / op_done handshake.
// Accepts one operation at a time, runs it for OP_LATENCY cycles, then
// advances the key manager state and gates the key output enables. The result
// depends only on the current state and the latched opcode.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   op_start    in   level request, held by the initiator until op_done
//   op[2:0]     in   opcode (0 Advance, 1 GenId, 2 GenSwOut, 3 GenHwOut,
//                    4 Disable, 5..7 illegal)
//   op_done     out  one-cycle completion pulse
//   op_err      out  operation rejected (meaningful only with op_done)
//   op_busy     out  operation in flight
//   state_o     out  current key manager state encoding
//   data_hw_en  out  hardware key output enable (sticky)
//   data_sw_en  out  software key output enable (sticky)
//   data_valid  out  one-cycle pulse: generated output valid
// -----------------------------------------------------------------------------
module keymgr_op_ctrl #(
  parameter int unsigned OP_LATENCY = 4  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_start,
  input  logic [2:0] op,
  output logic       op_done,
  output logic       op_err,
  output logic       op_busy,
  output logic [9:0] state_o,
  output logic       data_hw_en,
  output logic       data_sw_en,
  output logic       data_valid
);

  // Opcodes
  localparam logic [2:0] OpAdvance  = 3'd0;
  localparam logic [2:0] OpGenId    = 3'd1;
  localparam logic [2:0] OpGenSwOut = 3'd2;
  localparam logic [2:0] OpGenHwOut = 3'd3;
  localparam logic [2:0] OpDisable  = 3'd4;

  // Key manager state encodings
  localparam logic [9:0] StCtrlReset          = 10'b1101100001;
  localparam logic [9:0] StCtrlInit           = 10'b0100000100;
  localparam logic [9:0] StCtrlCreatorRootKey = 10'b1000011101;
  localparam logic [9:0] StCtrlOwnerIntKey    = 10'b0011110010;
  localparam logic [9:0] StCtrlOwnerKey       = 10'b1101111110;
  localparam logic [9:0] StCtrlDisabled       = 10'b0110001011;

  // Operation sequencing FSM
  localparam logic [1:0] FsmIdle = 2'd0;
  localparam logic [1:0] FsmBusy = 2'd1;
  localparam logic [1:0] FsmDone = 2'd2;

  localparam logic [3:0] LatM1 = 4'(OP_LATENCY - 1);

  logic [1:0] fsm_q, fsm_d;
  logic [3:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic [2:0] op_q, op_d;
  logic [9:0] st_q, st_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;
  logic       hw_en_q, hw_en_d;
  logic       sw_en_q, sw_en_d;

  logic       accept;
  logic       finish;
  logic [2:0] fin_op;

  function automatic logic is_key_state(input logic [9:0] s);
    return (s == StCtrlCreatorRootKey) || (s == StCtrlOwnerIntKey) ||
           (s == StCtrlOwnerKey);
  endfunction

  function automatic logic is_valid_state(input logic [9:0] s);
    return is_key_state(s) || (s == StCtrlReset) || (s == StCtrlInit) ||
           (s == StCtrlDisabled);
  endfunction

  assign accept = (fsm_q == FsmIdle) && op_start && armed_q;

  // With OP_LATENCY == 1 the operation completes straight out of the accept
  // edge, before op_q holds the opcode, so the result is taken from the port.
  assign finish = (fsm_q == FsmBusy && cnt_q <= 4'd1) ||
                  (accept && OP_LATENCY == 1);
  assign fin_op = (fsm_q == FsmIdle) ? op : op_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    op_d    = op_q;
    st_d    = st_q;
    err_d   = 1'b0;   // err / valid are single-cycle, aligned with op_done
    valid_d = 1'b0;
    hw_en_d = hw_en_q;
    sw_en_d = sw_en_q;

    case (fsm_q)
      FsmIdle: begin
        if (!op_start) armed_d = 1'b1;
        if (accept) begin
          armed_d = 1'b0;
          op_d    = op;
          cnt_d   = LatM1;
          hw_en_d = 1'b0;
          sw_en_d = 1'b0;
          fsm_d   = (OP_LATENCY == 1) ? FsmDone : FsmBusy;
        end
      end
      FsmBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) fsm_d = FsmDone;
      end
      FsmDone: begin
        // A drop seen during the Done cycle already re-arms, allowing the
        // next accept one cycle after Done.
        if (!op_start) armed_d = 1'b1;
        fsm_d = FsmIdle;
      end
      default: fsm_d = FsmIdle;
    endcase

    // Result of the completing operation, visible together with op_done.
    if (finish) begin
      case (fin_op)
        OpAdvance: begin
          case (st_q)
            StCtrlReset:          st_d = StCtrlInit;
            StCtrlInit:           st_d = StCtrlCreatorRootKey;
            StCtrlCreatorRootKey: st_d = StCtrlOwnerIntKey;
            StCtrlOwnerIntKey:    st_d = StCtrlOwnerKey;
            StCtrlOwnerKey:       st_d = StCtrlDisabled;
            default:              err_d = 1'b1;
          endcase
        end
        OpGenId, OpGenSwOut, OpGenHwOut: begin
          if (is_key_state(st_q)) begin
            valid_d = 1'b1;
            if (fin_op == OpGenSwOut) sw_en_d = 1'b1;
            if (fin_op == OpGenHwOut) hw_en_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        OpDisable: st_d = StCtrlDisabled;
        default:   err_d = 1'b1;
      endcase
    end

    // A corrupted state register collapses to Disabled regardless of any
    // operation in progress.
    if (!is_valid_state(st_q)) st_d = StCtrlDisabled;

    if (st_d != st_q) begin
      hw_en_d = 1'b0;
      sw_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      fsm_q   <= FsmIdle;
      cnt_q   <= 4'd0;
      armed_q <= 1'b1;
      op_q    <= OpAdvance;
      st_q    <= StCtrlReset;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      hw_en_q <= 1'b0;
      sw_en_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      op_q    <= op_d;
      st_q    <= st_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      hw_en_q <= hw_en_d;
      sw_en_q <= sw_en_d;
    end
  end

  assign op_done    = (fsm_q == FsmDone);
  assign op_busy    = (fsm_q == FsmBusy);
  assign op_err     = err_q;
  assign data_valid = valid_q;
  assign state_o    = st_q;
  // Enables are never granted outside a key state, whatever the flops hold.
  assign data_hw_en = hw_en_q & is_key_state(st_q);
  assign data_sw_en = sw_en_q & is_key_state(st_q);

endmodule

// File: tb/tb_keymgr_op_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keymgr_op_ctrl
//
// Table-driven bench for keymgr_op_ctrl. Each vector carries an opcode and
// the expected result; the expectation is queued when the request is driven
// and compared when op_done appears. Multi-cycle corners (held op_start,
// reset mid-operation) are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_keymgr_op_ctrl;

  localparam int LAT = 4;

  localparam logic [9:0] ST_RESET = 10'b1101100001;
  localparam logic [9:0] ST_INIT  = 10'b0100000100;
  localparam logic [9:0] ST_CRK   = 10'b1000011101;
  localparam logic [9:0] ST_OIK   = 10'b0011110010;
  localparam logic [9:0] ST_OK    = 10'b1101111110;
  localparam logic [9:0] ST_DIS   = 10'b0110001011;

  localparam logic [2:0] ADV = 3'd0, GID = 3'd1, GSW = 3'd2, GHW = 3'd3,
                         DIS = 3'd4;

  typedef struct {
    logic [2:0] op;
    logic       drop_mid;
    logic       err;
    logic [9:0] st;
    logic       valid;
    logic       hw;
    logic       sw;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_start = 1'b0;
  logic [2:0] op = 3'd0;
  logic       op_done, op_err, op_busy, data_hw_en, data_sw_en, data_valid;
  logic [9:0] state_o;

  int n_pass = 0;
  int n_checks = 0;

  vec_t exp_q[$];
  vec_t seq_a[8];
  vec_t seq_b[4];
  vec_t seq_c[8];

  always #5 clk = ~clk;

  keymgr_op_ctrl #(.OP_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_start  (op_start),
    .op        (op),
    .op_done   (op_done),
    .op_err    (op_err),
    .op_busy   (op_busy),
    .state_o   (state_o),
    .data_hw_en(data_hw_en),
    .data_sw_en(data_sw_en),
    .data_valid(data_valid)
  );

  function automatic vec_t mk(input logic [2:0] o, input logic dm,
                              input logic e, input logic [9:0] s,
                              input logic v, input logic h, input logic w);
    vec_t r;
    r.op = o; r.drop_mid = dm; r.err = e; r.st = s;
    r.valid = v; r.hw = h; r.sw = w;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    op_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one operation; expected result goes on the scoreboard at drive time
  // and is retired when op_done is observed.
  task automatic run_op(input vec_t v);
    vec_t e;
    int   n_done;
    int   busy_n;
    bit   seen;
    @(negedge clk);
    op_start = 1'b1;
    op = v.op;
    exp_q.push_back(v);
    busy_n = 0;
    seen = 1'b0;
    n_done = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        op = 3'd5;  // opcode must already be latched
        check("en_cleared_after_accept", 32'({data_hw_en, data_sw_en}), 32'd0);
        if (v.drop_mid) op_start = 1'b0;
      end
      if (op_done) begin
        seen = 1'b1;
        n_done = n;
        break;
      end
      if (op_busy) busy_n++;
    end
    check("op_done_seen", 32'(seen), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      e = v;
    end else begin
      e = exp_q.pop_front();
    end
    if (seen) begin
      check("latency", 32'(n_done), 32'(LAT));
      check("busy_cycles", 32'(busy_n), 32'(LAT - 1));
      check("busy_at_done", 32'(op_busy), 32'd0);
      check("op_err", 32'(op_err), 32'(e.err));
      check("state_at_done", 32'(state_o), 32'(e.st));
      check("valid_at_done", 32'(data_valid), 32'(e.valid));
      check("hw_en_at_done", 32'(data_hw_en), 32'(e.hw));
      check("sw_en_at_done", 32'(data_sw_en), 32'(e.sw));
    end
    op_start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'(op_done), 32'd0);
    check("valid_one_cycle", 32'(data_valid), 32'd0);
    check("hw_en_sticky", 32'(data_hw_en), 32'(e.hw));
    check("sw_en_sticky", 32'(data_sw_en), 32'(e.sw));
    check("state_hold", 32'(state_o), 32'(e.st));
  endtask

  initial begin
    int n_done_pulses;
    int n_valid_pulses;
    bit done_seen;

    // Advance to OwnerKey, generate outputs there, then an illegal opcode.
    seq_a[0] = mk(ADV,  1'b0, 1'b0, ST_INIT, 1'b0, 1'b0, 1'b0);
    seq_a[1] = mk(ADV,  1'b0, 1'b0, ST_CRK,  1'b0, 1'b0, 1'b0);
    seq_a[2] = mk(ADV,  1'b1, 1'b0, ST_OIK,  1'b0, 1'b0, 1'b0);
    seq_a[3] = mk(ADV,  1'b0, 1'b0, ST_OK,   1'b0, 1'b0, 1'b0);
    seq_a[4] = mk(GHW,  1'b0, 1'b0, ST_OK,   1'b1, 1'b1, 1'b0);
    seq_a[5] = mk(GID,  1'b0, 1'b0, ST_OK,   1'b1, 1'b0, 1'b0);
    seq_a[6] = mk(GSW,  1'b0, 1'b0, ST_OK,   1'b1, 1'b0, 1'b1);
    seq_a[7] = mk(3'd6, 1'b0, 1'b1, ST_OK,   1'b0, 1'b0, 1'b0);
    // Gen ops outside a key state are rejected.
    seq_b[0] = mk(ADV,  1'b0, 1'b0, ST_INIT, 1'b0, 1'b0, 1'b0);
    seq_b[1] = mk(GID,  1'b0, 1'b1, ST_INIT, 1'b0, 1'b0, 1'b0);
    seq_b[2] = mk(GSW,  1'b0, 1'b1, ST_INIT, 1'b0, 1'b0, 1'b0);
    seq_b[3] = mk(GHW,  1'b0, 1'b1, ST_INIT, 1'b0, 1'b0, 1'b0);
    // Disable from OwnerIntKey, then everything is rejected.
    seq_c[0] = mk(ADV,  1'b0, 1'b0, ST_INIT, 1'b0, 1'b0, 1'b0);
    seq_c[1] = mk(ADV,  1'b0, 1'b0, ST_CRK,  1'b0, 1'b0, 1'b0);
    seq_c[2] = mk(GSW,  1'b0, 1'b0, ST_CRK,  1'b1, 1'b0, 1'b1);
    seq_c[3] = mk(ADV,  1'b0, 1'b0, ST_OIK,  1'b0, 1'b0, 1'b0);
    seq_c[4] = mk(DIS,  1'b0, 1'b0, ST_DIS,  1'b0, 1'b0, 1'b0);
    seq_c[5] = mk(ADV,  1'b0, 1'b1, ST_DIS,  1'b0, 1'b0, 1'b0);
    seq_c[6] = mk(GHW,  1'b0, 1'b1, ST_DIS,  1'b0, 1'b0, 1'b0);
    seq_c[7] = mk(GSW,  1'b0, 1'b1, ST_DIS,  1'b0, 1'b0, 1'b0);

    do_reset();
    @(negedge clk);
    check("rst_op_done", 32'(op_done), 32'd0);
    check("rst_op_err", 32'(op_err), 32'd0);
    check("rst_op_busy", 32'(op_busy), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_enables", 32'({data_hw_en, data_sw_en}), 32'd0);
    check("rst_state", 32'(state_o), 32'(ST_RESET));

    foreach (seq_a[i]) run_op(seq_a[i]);

    // op_start held high for 20 cycles: exactly one completion.
    n_done_pulses = 0;
    n_valid_pulses = 0;
    @(negedge clk);
    op_start = 1'b1;
    op = GID;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (op_done) begin
        n_done_pulses++;
        check("held_err", 32'(op_err), 32'd0);
      end
      if (data_valid) n_valid_pulses++;
    end
    op_start = 1'b0;
    check("held_done_count", 32'(n_done_pulses), 32'd1);
    check("held_valid_count", 32'(n_valid_pulses), 32'd1);
    check("held_state", 32'(state_o), 32'(ST_OK));

    do_reset();
    foreach (seq_b[i]) run_op(seq_b[i]);

    // Reset asserted during the third cycle of an OpAdvance discards it.
    do_reset();
    @(negedge clk);
    op_start = 1'b1;
    op = ADV;
    @(negedge clk);                       // cycle T0+1
    @(negedge clk);                       // cycle T0+2
    check("midrst_busy_before", 32'(op_busy), 32'd1);
    rst_n = 1'b0;
    op_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 32'(op_busy), 32'd0);
    check("midrst_state", 32'(state_o), 32'(ST_RESET));
    done_seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (op_done) done_seen = 1'b1;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    check("midrst_state_after", 32'(state_o), 32'(ST_RESET));

    do_reset();
    foreach (seq_c[i]) run_op(seq_c[i]);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
